// File: rtl/dataflow_rec_pkg.sv
// Shared types for the ap_ctrl transaction recorder: record layout, FSM states, flush timeout.
// Optional stall field is enabled by defining AP_CTRL_STALL_CNT_EN.
package dataflow_rec_pkg;

    // Record timestamp fields are fixed at this width; narrower TS_W values are zero-extended.
    localparam int REC_TS_W      = 32;
    localparam int FLUSH_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0]         txn_id;
        logic [REC_TS_W-1:0] start_ts;
        logic [REC_TS_W-1:0] latency;
`ifdef AP_CTRL_STALL_CNT_EN
        logic [15:0]         stall;
`endif
    } rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_recorder_fifo.sv
// Synchronous record FIFO with full/empty flags; writes while full are discarded.
module rec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 80
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_ok_s   = wr_en_i & ~full_o;
    assign rd_ok_s   = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // Storage array, cleared on reset so the idle read port is deterministic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

endmodule

// File: rtl/ap_ctrl_recorder.sv
// Observes an ap_ctrl handshake and records {txn_id, start_ts, latency} per completion.
// Define AP_CTRL_STALL_CNT_EN to add a per-transaction ap_continue stall count to each record.
module ap_ctrl_recorder
    import dataflow_rec_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic ap_start,
    input  logic ap_ready,
    input  logic ap_done,
    input  logic ap_continue,
    input  logic finish,
    output logic rec_valid,
    input  logic rec_ready,
    output rec_t rec_data,
    output logic ovf,
    output logic drain_done
);

    localparam int REC_W       = $bits(rec_t);
    localparam int FLUSH_CNT_W = $clog2(FLUSH_TIMEOUT);

    logic [TS_W-1:0]        ts_q, ts_d;
    logic [TS_W-1:0]        sq0_q, sq0_d, sq1_q, sq1_d;
    logic [1:0]             sq_cnt_q, sq_cnt_d;
    logic [15:0]            txn_q, txn_d;
    logic                   ovf_q, ovf_d;
    logic                   drain_done_q;
    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic                   start_acc_s;
    logic                   comp_s;
    logic                   comp_ok_s;
    logic                   q_ovf_s;
    logic [TS_W-1:0]        lat_s;
    rec_t                   rec_wr_s;
    logic [REC_W-1:0]       rd_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    // Starts are only tracked before finish is requested.
    assign start_acc_s = ap_start & ap_ready & ~finish &
                         ((state_q == ST_IDLE) || (state_q == ST_BUSY));
    assign comp_s      = ap_done & ap_continue;
    assign comp_ok_s   = comp_s && (sq_cnt_q != 2'd0);
    assign lat_s       = ts_q - sq0_q;
    assign ts_d        = ts_q + TS_W'(1);

    // Start queue: pop the oldest on completion first, then push the new start.
    always_comb begin
        sq_cnt_d = sq_cnt_q;
        sq0_d    = sq0_q;
        sq1_d    = sq1_q;
        q_ovf_s  = 1'b0;
        if (comp_s) begin
            if (sq_cnt_q != 2'd0) begin
                sq0_d    = sq1_q;
                sq_cnt_d = sq_cnt_q - 2'd1;
            end else begin
                q_ovf_s = 1'b1;
            end
        end else begin
            sq_cnt_d = sq_cnt_q;
        end
        if (start_acc_s) begin
            if (sq_cnt_d == 2'd2) begin
                q_ovf_s = 1'b1;
            end else if (sq_cnt_d == 2'd0) begin
                sq0_d    = ts_q;
                sq_cnt_d = 2'd1;
            end else begin
                sq1_d    = ts_q;
                sq_cnt_d = 2'd2;
            end
        end else begin
            sq1_d = sq1_d;
        end
    end

    assign txn_d = comp_ok_s ? (txn_q + 16'd1) : txn_q;
    assign ovf_d = ovf_q | q_ovf_s | (comp_ok_s & fifo_full_s);

`ifdef AP_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Stall count belongs to the oldest outstanding transaction and restarts on its completion.
    always_comb begin
        stall_d = stall_q;
        if (comp_ok_s) begin
            stall_d = 16'd0;
        end else if (ap_done && !ap_continue && (sq_cnt_q != 2'd0)) begin
            stall_d = sat_inc16(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign rec_wr_s.stall = stall_q;
`endif

    assign rec_wr_s.txn_id   = txn_q;
    assign rec_wr_s.start_ts = REC_TS_W'(sq0_q);
    assign rec_wr_s.latency  = REC_TS_W'(lat_s);

    // Lifecycle FSM with a bounded flush window.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (finish) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = {FLUSH_CNT_W{1'b0}};
                end else if (sq_cnt_d != 2'd0) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (((sq_cnt_q == 2'd0) && fifo_empty_s) ||
                    (flush_cnt_q == FLUSH_CNT_W'(FLUSH_TIMEOUT - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q         <= {TS_W{1'b0}};
            sq0_q        <= {TS_W{1'b0}};
            sq1_q        <= {TS_W{1'b0}};
            sq_cnt_q     <= 2'd0;
            txn_q        <= 16'd0;
            ovf_q        <= 1'b0;
            drain_done_q <= 1'b0;
            state_q      <= ST_IDLE;
            flush_cnt_q  <= {FLUSH_CNT_W{1'b0}};
        end else begin
            ts_q         <= ts_d;
            sq0_q        <= sq0_d;
            sq1_q        <= sq1_d;
            sq_cnt_q     <= sq_cnt_d;
            txn_q        <= txn_d;
            ovf_q        <= ovf_d;
            drain_done_q <= (state_d == ST_DONE);
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_rec_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (comp_ok_s),
        .wr_data_i (rec_wr_s),
        .rd_en_i   (rec_ready),
        .rd_data_o (rd_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign rec_valid  = ~fifo_empty_s;
    assign rec_data   = rd_data_s;
    assign ovf        = ovf_q;
    assign drain_done = drain_done_q;

endmodule

// File: tb/tb_ap_ctrl_recorder.sv
// Directed bench for ap_ctrl_recorder: a per-cycle vector table plus multi-cycle scenarios.
module tb_ap_ctrl_recorder;
    import dataflow_rec_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
    logic finish = 1'b0, rec_ready = 1'b0;
    logic rec_valid, ovf, drain_done;
    rec_t rec_data;

    logic d8_start = 1'b0, d8_ready = 1'b0, d8_done = 1'b0, d8_cont = 1'b0;
    logic d8_finish = 1'b0, d8_rr = 1'b0;
    logic d8_valid, d8_ovf, d8_dd;
    rec_t d8_data;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ap_ctrl_recorder #(.FIFO_DEPTH(8), .TS_W(32)) u_dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .ovf(ovf), .drain_done(drain_done)
    );

    // Narrow-timestamp instance so the wrap case is reachable in a few hundred cycles.
    ap_ctrl_recorder #(.FIFO_DEPTH(8), .TS_W(8)) u_dut8 (
        .clock(clock), .reset(reset), .ap_start(d8_start), .ap_ready(d8_ready),
        .ap_done(d8_done), .ap_continue(d8_cont), .finish(d8_finish),
        .rec_valid(d8_valid), .rec_ready(d8_rr), .rec_data(d8_data),
        .ovf(d8_ovf), .drain_done(d8_dd)
    );

    typedef struct {
        logic        st, dn, fin, rr;
        logic        rdy, cn;
        logic        e_valid, e_ovf, e_dd;
        logic        chk;
        logic [15:0] e_txn;
        logic [31:0] e_sts, e_lat;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic set_in(input logic st, input logic rdy, input logic dn, input logic cn,
                          input logic fin, input logic rr);
        ap_start = st; ap_ready = rdy; ap_done = dn; ap_continue = cn;
        finish = fin; rec_ready = rr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        d8_start = 1'b0; d8_ready = 1'b0; d8_done = 1'b0; d8_cont = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rec(input string nm, input rec_t act, input logic [15:0] txn,
                           input logic [31:0] sts, input logic [31:0] lat);
        n_vec++;
        if (act.txn_id !== txn || act.start_ts !== sts || act.latency !== lat) begin
            n_err++;
            $display("FAIL %s: got {txn %0d, start %0h, lat %0d}, expected {txn %0d, start %0h, lat %0d}",
                     nm, act.txn_id, act.start_ts, act.latency, txn, sts, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sts_exp [9];

        // st dn fin rr rdy cn | valid ovf dd | chk txn start lat   (vector i applied at ts=i)
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1, 1'b1,1'b0,1'b0, 1'b1, 16'd0, 32'd1, 32'd1};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1, 1'b0,1'b1,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 1'b0,1'b1,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1, 1'b1,1'b1,1'b0, 1'b1, 16'd1, 32'd5, 32'd1};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1,1'b0, 1'b1, 16'd2, 32'd6, 32'd1};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0, 1'b0,1'b1,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b1,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0, 1'b0,1'b1,1'b0, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 1'b0,1'b1,1'b1, 1'b0, 16'd0, 32'd0, 32'd0};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1, 1'b0,1'b1,1'b1, 1'b0, 16'd0, 32'd0, 32'd0};

        do_reset();
        chk_bit("reset.valid", rec_valid, 1'b0);
        chk_bit("reset.ovf", ovf, 1'b0);
        chk_bit("reset.drain_done", drain_done, 1'b0);

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].st, tbl[i].rdy, tbl[i].dn, tbl[i].cn, tbl[i].fin, tbl[i].rr);
            tick();
            chk_bit($sformatf("v%0d.valid", i), rec_valid, tbl[i].e_valid);
            chk_bit($sformatf("v%0d.ovf", i), ovf, tbl[i].e_ovf);
            chk_bit($sformatf("v%0d.drain_done", i), drain_done, tbl[i].e_dd);
            if (tbl[i].chk) chk_rec($sformatf("v%0d.rec", i), rec_data, tbl[i].e_txn, tbl[i].e_sts, tbl[i].e_lat);
        end

        // Start at ts=10, completion at ts=25.
        do_reset();
        while (cyc < 10) tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (cyc < 25) tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_bit("basic.valid_at_completion", rec_valid, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bit("basic.valid_at_ts26", rec_valid, 1'b1);
        chk_rec("basic.rec", rec_data, 16'd0, 32'd10, 32'd15);

        // Timestamp wrap on the 8-bit instance: start at 8'hF0, complete at 8'h05.
        while (cyc < 240) tick();
        d8_start = 1'b1; d8_ready = 1'b1;
        tick();
        d8_start = 1'b0; d8_ready = 1'b0;
        while (cyc < 261) tick();
        d8_done = 1'b1; d8_cont = 1'b1;
        tick();
        d8_done = 1'b0; d8_cont = 1'b0;
        chk_bit("wrap.valid", d8_valid, 1'b1);
        chk_rec("wrap.rec", d8_data, 16'd0, 32'h0000_00F0, 32'd21);

        // Three starts without completion: third dropped, first two kept.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk_bit("qfull.ovf_after_2", ovf, 1'b0);
        tick();
        chk_bit("qfull.ovf_after_3", ovf, 1'b1);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_rec("qfull.rec0", rec_data, 16'd0, 32'd0, 32'd3);
        rec_ready = 1'b1;
        tick();
        chk_rec("qfull.rec1", rec_data, 16'd1, 32'd1, 32'd3);
        tick();
        rec_ready = 1'b0;
        chk_bit("qfull.empty", rec_valid, 1'b0);

        // Nine completions into an 8-deep FIFO with no reader.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sts_exp[i] = 32'(cyc);
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7) chk_bit("ffull.ovf_after_8", ovf, 1'b0);
        end
        chk_bit("ffull.ovf_after_9", ovf, 1'b1);
        tick();
        tick();
        chk_bit("ffull.valid_held", rec_valid, 1'b1);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_rec($sformatf("ffull.rec%0d", i), rec_data, 16'(i), sts_exp[i], 32'd1);
            tick();
        end
        rec_ready = 1'b0;
        chk_bit("ffull.drained", rec_valid, 1'b0);

        // Finish with one transaction outstanding; completion arrives 4 cycles later.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bit("flush.dd_early", drain_done, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bit("flush.valid", rec_valid, 1'b1);
        chk_rec("flush.rec", rec_data, 16'd0, 32'd0, 32'd5);
        tick();
        chk_bit("flush.dd_while_held", drain_done, 1'b0);
        chk_bit("flush.ovf", ovf, 1'b0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        for (int k = 0; k < 20 && !drain_done; k++) tick();
        chk_bit("flush.drain_done", drain_done, 1'b1);
        chk_bit("flush.valid_after", rec_valid, 1'b0);

        // Reset mid-transaction: the next completion has no matching start.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_bit("rstmid.ovf", ovf, 1'b1);
        chk_bit("rstmid.valid", rec_valid, 1'b0);

`ifdef AP_CTRL_STALL_CNT_EN
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (rec_data.stall !== 16'd7) begin
            n_err++;
            $display("FAIL stall.count: got %0d, expected 7", rec_data.stall);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_recorder.md
AP_CTRL_RECORDER -- requirements
Module: ap_ctrl_recorder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, record FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TS_W, default 32, timestamp/latency width.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ap_start, ap_ready, ap_done, ap_continue  input  1 each  tapped ap_ctrl handshake of the observed module.
REQ-006 SHALL have port finish  input  1  end-of-simulation request.
REQ-007 SHALL have port rec_valid  output  1  record available.
REQ-008 SHALL have port rec_ready  input  1  downstream dump stage accepts the record.
REQ-009 SHALL have port rec_data  output  rec_t  {txn_id[15:0], start_ts, latency}, plus stall[15:0] when STALL_CNT_EN is defined.
REQ-010 SHALL have port ovf  output  1  sticky: a start or a record was dropped.
REQ-011 SHALL have port drain_done  output  1  flush complete.

Function
REQ-012 SHALL run a free-running TS_W-bit timestamp that increments every cycle and wraps to 0.
REQ-013 SHALL treat a start as accepted in a cycle with ap_start=1 and ap_ready=1, and SHALL push the current timestamp into a 2-entry start queue.
REQ-014 SHALL treat a completion as a cycle with ap_done=1 and ap_continue=1, SHALL pop the oldest start, and SHALL form latency = ts - start_ts, modulo 2^TS_W.
REQ-015 SHALL write the completed record into the FIFO on the cycle after completion, so rec_valid rises 1 cycle after the completion when the FIFO was empty.
REQ-016 SHALL assign txn_id values 0,1,2,... in completion order, wrapping at 16'hFFFF to 0.
REQ-017 SHALL handle an accepted start and a completion in the same cycle: pop first, then push; queue occupancy is unchanged.
REQ-018 SHALL, on a start while the queue holds 2 entries, drop that start and set ovf.
REQ-019 SHALL, on a completion while the queue is empty, ignore the completion and set ovf.
REQ-020 SHALL, on a record write while the FIFO is full, drop the new record and set ovf; FIFO contents are unchanged.
REQ-021 SHALL keep rec_data stable while rec_valid=1 and rec_ready=0.
REQ-022 SHALL implement an FSM with states IDLE (queue empty), BUSY (queue non-empty), FLUSH (finish seen), DONE (drained).
REQ-023 SHALL make the transitions IDLE->BUSY on start, BUSY->IDLE when the queue empties, and any->FLUSH when finish=1.
REQ-024 SHALL, in FLUSH, ignore new starts, still record completions, and move to DONE when the queue and FIFO are both empty, or after 1024 cycles in FLUSH.
REQ-025 SHALL hold drain_done=1 only in DONE; DONE exits only by reset.

Reset
REQ-026 SHALL, on reset, clear timestamp, txn_id, start queue, FIFO pointers, ovf, rec_valid and drain_done to 0 and put the FSM in IDLE.
REQ-027 SHALL, on reset mid-transaction, discard outstanding starts; the first completion after reset is handled per REQ-019.

Configuration
REQ-028 SHALL gate the stall counter with macro AP_CTRL_STALL_CNT_EN.
REQ-029 SHALL, with AP_CTRL_STALL_CNT_EN defined, count cycles with ap_done=1 and ap_continue=0 for the oldest transaction, saturating at 16'hFFFF, and append the count to rec_data as stall.
REQ-030 SHALL, without AP_CTRL_STALL_CNT_EN, omit the stall counter logic and the stall field entirely.

Structure
REQ-031 SHALL place rec_t, the FSM state enum, and the FLUSH_TIMEOUT=1024 constant in package dataflow_rec_pkg.
REQ-032 SHALL instantiate the record FIFO as sub-module rec_fifo (synchronous, FIFO_DEPTH, full/empty flags).

Verification
REQ-033 SHALL cover: a start at ts=10 and completion at ts=25 -> record {0,10,15}, with rec_valid rising at ts=26.
REQ-034 SHALL cover: start_ts=32'hFFFF_FFF0 and completion at ts=5 -> latency=21.
REQ-035 SHALL cover: 3 starts with no completion -> ovf=1, and the two queued start_ts values are preserved.
REQ-036 SHALL cover: rec_ready=0 with 9 completions -> 8 records held, ovf=1, records drained in order once rec_ready=1.
REQ-037 SHALL cover: finish with 1 transaction outstanding, completing 4 cycles later -> record emitted and drain_done=1 once the FIFO is read.
REQ-038 SHALL cover (AP_CTRL_STALL_CNT_EN): ap_continue held low for 7 cycles with ap_done=1 -> stall=7.
